// File: rtl/team_gpio_mux_wrapper.sv
// rtl/team_gpio_mux_wrapper.sv - Wishbone-programmed GPIO owner mux with break-before-make drain (option: GPIO_SYNC_EN)
module team_gpio_mux_wrapper #(
  parameter int                NUM_TEAMS     = 4,
  parameter int                GPIO_W        = 38,
  parameter logic [GPIO_W-1:0] RSVD_MASK     = 38'h1E,
  parameter int                SWITCH_CYCLES = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [NUM_TEAMS*GPIO_W-1:0]   team_gpio_out,
  input  logic [NUM_TEAMS*GPIO_W-1:0]   team_gpio_oeb,
  output logic [GPIO_W-1:0]             team_gpio_in,
  output logic [NUM_TEAMS-1:0]          team_en,
  input  logic [GPIO_W-1:0]             gpio_in,
  output logic [GPIO_W-1:0]             gpio_out,
  output logic [GPIO_W-1:0]             gpio_oeb,
  output logic                          irq
);

  localparam int SEL_W = $clog2(NUM_TEAMS);
  // Pins above 31 live in FORCE_HI; the bank is assumed to be 33..64 pins wide.
  localparam int HI_W = GPIO_W - 32;
  localparam int CNT_W = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SWITCH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_DRAIN = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_active_owner;
  logic [SEL_W-1:0]   r_ctrl_owner;
  logic               r_ctrl_en;
  logic [31:0]        r_force_lo;
  logic [HI_W-1:0]    r_force_hi;
  logic               r_err;
  logic               r_ack;
  logic [31:0]        r_dat;
  logic [GPIO_W-1:0]  r_gpio_out;
  logic [GPIO_W-1:0]  r_gpio_oeb;

  logic               w_req;
  logic               w_wr;
  logic [1:0]         w_addr;
  logic [7:0]         w_new_owner8;
  logic [SEL_W-1:0]   w_new_owner;
  logic               w_new_en;
  logic               w_illegal;
  logic               w_ctrl_wr;
  logic               w_ctrl_accept;
  logic               w_ctrl_change;
  logic               w_err_clr;
  logic [31:0]        w_ctrl_word;
  logic [31:0]        w_status;
  logic [31:0]        w_rdata;
  logic [GPIO_W-1:0]  w_force;
  logic [GPIO_W-1:0]  w_block;
  logic [GPIO_W-1:0]  w_own_out;
  logic [GPIO_W-1:0]  w_own_oeb;
  logic [NUM_TEAMS-1:0] w_team_en;
  logic               w_unused_adr;

  // Byte-lane merge of a write into an existing 32-bit register value.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  sel);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return v;
  endfunction

  assign w_unused_adr = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

  // A new request only when no ack is outstanding, so a held stb acks every other cycle.
  assign w_req  = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr   = w_req & wbs_we_i;
  assign w_addr = wbs_adr_i[3:2];

  // The owner range check uses the full byte so out-of-range values are not hidden by truncation.
  assign w_new_owner8  = wbs_sel_i[0] ? wbs_dat_i[7:0] : 8'(r_ctrl_owner);
  assign w_new_owner   = w_new_owner8[SEL_W-1:0];
  assign w_new_en      = wbs_sel_i[1] ? wbs_dat_i[8] : r_ctrl_en;
  assign w_illegal     = w_new_en && (int'(w_new_owner8) >= NUM_TEAMS);
  assign w_ctrl_wr     = w_wr && (w_addr == 2'd0);
  assign w_ctrl_accept = w_ctrl_wr && !w_illegal;
  assign w_ctrl_change = w_ctrl_accept &&
                         ((w_new_owner != r_ctrl_owner) || (w_new_en != r_ctrl_en));
  assign w_err_clr     = w_wr && (w_addr == 2'd1) && wbs_sel_i[1] && wbs_dat_i[10];

  // Register read views.
  always_comb begin
    w_ctrl_word = '0;
    w_ctrl_word[SEL_W-1:0] = r_ctrl_owner;
    w_ctrl_word[8] = r_ctrl_en;
    w_status = '0;
    w_status[SEL_W-1:0] = r_active_owner;
    w_status[8]  = (r_state == S_RUN);
    w_status[9]  = (r_state == S_DRAIN);
    w_status[10] = r_err;
    case (w_addr)
      2'd0:    w_rdata = w_ctrl_word;
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = r_force_lo;
      default: w_rdata = 32'(r_force_hi);
    endcase
  end

  // Wishbone ack/read data and the CTRL, FORCE and err registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_ctrl_owner <= '0;
      r_ctrl_en    <= 1'b0;
      r_force_lo   <= '0;
      r_force_hi   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wbs_we_i) ? w_rdata : 32'd0;
      if (w_ctrl_accept) begin
        r_ctrl_owner <= w_new_owner;
        r_ctrl_en    <= w_new_en;
      end
      if (w_wr && (w_addr == 2'd2)) begin
        r_force_lo <= f_merge(r_force_lo, wbs_dat_i, wbs_sel_i);
      end
      if (w_wr && (w_addr == 2'd3)) begin
        r_force_hi <= HI_W'(f_merge(32'(r_force_hi), wbs_dat_i, wbs_sel_i));
      end
      // Setting wins over clearing if both ever coincide.
      if (w_ctrl_wr && w_illegal) begin
        r_err <= 1'b1;
      end else if (w_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Ownership FSM: every owner/enable change drains before the new owner is granted.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state        <= S_OFF;
      r_cnt          <= '0;
      r_active_owner <= '0;
    end else if (w_ctrl_change) begin
      r_state <= S_DRAIN;
      r_cnt   <= CNT_LOAD;
    end else if (r_state == S_DRAIN) begin
      if (r_cnt == '0) begin
        if (r_ctrl_en) begin
          r_state        <= S_RUN;
          r_active_owner <= r_ctrl_owner;
        end else begin
          r_state <= S_OFF;
        end
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Select the active owner's slice of the team buses.
  always_comb begin
    w_own_out = '0;
    w_own_oeb = '1;
    for (int k = 0; k < NUM_TEAMS; k++) begin
      if (r_active_owner == SEL_W'(k)) begin
        w_own_out = team_gpio_out[k*GPIO_W +: GPIO_W];
        w_own_oeb = team_gpio_oeb[k*GPIO_W +: GPIO_W];
      end
    end
  end

  assign w_force = {r_force_hi, r_force_lo};
  assign w_block = RSVD_MASK | w_force;

  // Registered pad drive: only RUN lets the owner through, blocked pins always read as inputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_gpio_out <= '0;
      r_gpio_oeb <= '1;
    end else if (r_state == S_RUN) begin
      r_gpio_out <= w_own_out & ~w_block;
      r_gpio_oeb <= w_own_oeb | w_block;
    end else begin
      r_gpio_out <= '0;
      r_gpio_oeb <= '1;
    end
  end

  // One-hot grant for the owner while running.
  always_comb begin
    w_team_en = '0;
    if (r_state == S_RUN) w_team_en[r_active_owner] = 1'b1;
  end

`ifdef GPIO_SYNC_EN
  logic [GPIO_W-1:0] r_sync1;
  logic [GPIO_W-1:0] r_sync2;

  // Two-flop synchroniser for asynchronous pad inputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

  assign team_gpio_in = r_sync2 & ~RSVD_MASK;
`else
  assign team_gpio_in = gpio_in & ~RSVD_MASK;
`endif

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign gpio_out  = r_gpio_out;
  assign gpio_oeb  = r_gpio_oeb;
  assign team_en   = w_team_en;
  assign irq       = r_err;

endmodule

// File: tb/tb_team_gpio_mux_wrapper.sv
// tb/tb_team_gpio_mux_wrapper.sv - directed self-checking bench for team_gpio_mux_wrapper
module tb_team_gpio_mux_wrapper;
  localparam int NUM_TEAMS = 4;
  localparam int GPIO_W = 38;
  localparam logic [GPIO_W-1:0] ALL_IN  = 38'h3F_FFFF_FFFF;
  localparam logic [GPIO_W-1:0] T1_OUT  = 38'h25_A5A5_A5A5;
  localparam logic [GPIO_W-1:0] T1_PAD  = 38'h25_A5A5_A5A1;
  localparam logic [GPIO_W-1:0] T2_PAD  = 38'h3F_FFFF_FFE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_i = 32'h0;
  logic ack;
  logic [31:0] dat_o;
  logic [NUM_TEAMS*GPIO_W-1:0] t_out = '0;
  logic [NUM_TEAMS*GPIO_W-1:0] t_oeb = '1;
  logic [GPIO_W-1:0] t_in;
  logic [NUM_TEAMS-1:0] t_en;
  logic [GPIO_W-1:0] p_in = '0;
  logic [GPIO_W-1:0] p_out, p_oeb;
  logic irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  team_gpio_mux_wrapper dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .team_gpio_out(t_out), .team_gpio_oeb(t_oeb), .team_gpio_in(t_in), .team_en(t_en),
    .gpio_in(p_in), .gpio_out(p_out), .gpio_oeb(p_oeb), .irq(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    cyc = 0; stb = 0; we = 0; sel = 4'h0;
  endtask

  task automatic start_read(input logic [1:0] a);
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = {28'h0, a, 2'b00};
  endtask

  // Returns in the ack cycle with the bus released.
  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = 1; sel = s; adr = {28'h0, a, 2'b00}; dat_i = d;
    tick();
    bus_idle();
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d, output logic a_seen);
    start_read(a);
    tick();
    a_seen = ack;
    d = dat_o;
    bus_idle();
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    checks++; if (p_oeb !== ALL_IN) begin errors++; $display("FAIL rst_oeb: got %h want %h", p_oeb, ALL_IN); end
    checks++; if (p_out !== '0) begin errors++; $display("FAIL rst_out: got %h want 0", p_out); end
    checks++; if (t_en !== 4'b0000) begin errors++; $display("FAIL rst_team_en: got %b want 0000", t_en); end
    checks++; if (irq !== 1'b0 || ack !== 1'b0 || dat_o !== 32'h0) begin errors++; $display("FAIL rst_wb: irq %b ack %b dat %h want 0 0 0", irq, ack, dat_o); end
    checks++; if (t_in !== '0) begin errors++; $display("FAIL rst_team_in: got %h want 0", t_in); end
    start_read(2'd1);
    tick();
    checks++; if (ack !== 1'b1 || dat_o !== 32'h0) begin errors++; $display("FAIL rst_status: ack %b dat %h want 1 00000000", ack, dat_o); end
    bus_idle();
    tick();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_single: ack %b want 0", ack); end
  endtask

  task automatic test_held_stb();
    start_read(2'd0);
    tick();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL held_ack1: ack %b want 1", ack); end
    tick();
    checks++; if (ack !== 1'b0 || dat_o !== 32'h0) begin errors++; $display("FAIL held_gap: ack %b dat %h want 0 0", ack, dat_o); end
    tick();
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL held_ack2: ack %b want 1", ack); end
    bus_idle();
    tick();
  endtask

  task automatic test_drain_owner2();
    t_out[2*GPIO_W +: GPIO_W] = '1;
    t_oeb[2*GPIO_W +: GPIO_W] = '0;
    t_out[1*GPIO_W +: GPIO_W] = T1_OUT;
    t_oeb[1*GPIO_W +: GPIO_W] = '0;
    wb_write(2'd0, 32'h0000_0102, 4'b0011);
    checks++; if (ack !== 1'b1 || t_en !== 4'b0000) begin errors++; $display("FAIL d_t1: ack %b en %b want 1 0000", ack, t_en); end
    tick();
    checks++; if (p_oeb !== ALL_IN || t_en !== 4'b0000) begin errors++; $display("FAIL d_t2: oeb %h en %b want all-in 0000", p_oeb, t_en); end
    start_read(2'd1);
    tick();
    checks++; if (dat_o !== 32'h0000_0200) begin errors++; $display("FAIL d_busy_early: got %h want 00000200", dat_o); end
    bus_idle();
    tick();
    checks++; if (p_oeb !== ALL_IN || t_en !== 4'b0000) begin errors++; $display("FAIL d_t4: oeb %h en %b want all-in 0000", p_oeb, t_en); end
    start_read(2'd1);
    tick();
    checks++; if (dat_o !== 32'h0000_0200) begin errors++; $display("FAIL d_busy_late: got %h want 00000200", dat_o); end
    checks++; if (t_en !== 4'b0100 || p_oeb !== ALL_IN) begin errors++; $display("FAIL d_t5: en %b oeb %h want 0100 all-in", t_en, p_oeb); end
    bus_idle();
    tick();
    checks++; if (p_out !== T2_PAD || p_oeb !== 38'h1E) begin errors++; $display("FAIL d_t6_pads: out %h oeb %h want %h 1e", p_out, p_oeb, T2_PAD); end
    start_read(2'd1);
    tick();
    checks++; if (dat_o !== 32'h0000_0102) begin errors++; $display("FAIL d_run_status: got %h want 00000102", dat_o); end
    bus_idle();
    tick();
  endtask

  task automatic test_switch_owner1();
    int n_input;
    logic two_hot;
    n_input = 0;
    two_hot = 0;
    wb_write(2'd0, 32'h0000_0101, 4'b0011);
    for (int i = 1; i <= 7; i++) begin
      if (p_oeb === ALL_IN) n_input++;
      if ($countones(t_en) > 1) two_hot = 1;
      tick();
    end
    checks++; if (n_input !== 4) begin errors++; $display("FAIL sw_input_cycles: got %0d want 4", n_input); end
    checks++; if (two_hot !== 1'b0) begin errors++; $display("FAIL sw_two_hot: got %b want 0", two_hot); end
    checks++; if (p_out !== T1_PAD || p_oeb !== 38'h1E || t_en !== 4'b0010) begin errors++; $display("FAIL sw_final: out %h oeb %h en %b want %h 1e 0010", p_out, p_oeb, t_en, T1_PAD); end
  endtask

  task automatic test_illegal_owner();
    logic [31:0] d;
    logic a;
    wb_write(2'd0, 32'h0000_0105, 4'b0011);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ill_ack: ack %b want 1", ack); end
    tick();
    checks++; if (irq !== 1'b1 || t_en !== 4'b0010) begin errors++; $display("FAIL ill_irq: irq %b en %b want 1 0010", irq, t_en); end
    wb_read(2'd0, d, a);
    checks++; if (d !== 32'h0000_0101) begin errors++; $display("FAIL ill_ctrl: got %h want 00000101", d); end
    tick();
    wb_read(2'd1, d, a);
    checks++; if (d !== 32'h0000_0501) begin errors++; $display("FAIL ill_status: got %h want 00000501", d); end
    tick();
    wb_write(2'd1, 32'h0000_0400, 4'b0010);
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL err_clear_irq: irq %b want 0", irq); end
    wb_read(2'd1, d, a);
    checks++; if (d !== 32'h0000_0101) begin errors++; $display("FAIL err_clear_status: got %h want 00000101", d); end
    tick();
  endtask

  task automatic test_force();
    logic [31:0] d;
    logic a;
    checks++; if (p_out[0] !== 1'b1) begin errors++; $display("FAIL f_pre: out0 %b want 1", p_out[0]); end
    wb_write(2'd2, 32'h0000_0001, 4'b0001);
    checks++; if (t_en !== 4'b0010) begin errors++; $display("FAIL f_en_t1: en %b want 0010", t_en); end
    tick();
    checks++; if (p_out !== 38'h25_A5A5_A5A0 || p_oeb !== 38'h1F || t_en !== 4'b0010) begin errors++; $display("FAIL f_pin0: out %h oeb %h en %b want 25a5a5a5a0 1f 0010", p_out, p_oeb, t_en); end
    wb_read(2'd1, d, a);
    checks++; if (d !== 32'h0000_0101) begin errors++; $display("FAIL f_nodrain: got %h want 00000101", d); end
    tick();
    wb_write(2'd2, 32'hFFFF_FF00, 4'b0000);
    tick();
    wb_read(2'd2, d, a);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL f_sel0: got %h want 00000001", d); end
    tick();
    wb_write(2'd3, 32'hFFFF_FFFF, 4'b1111);
    tick(); tick();
    wb_read(2'd3, d, a);
    checks++; if (d !== 32'h0000_003F) begin errors++; $display("FAIL f_hi_read: got %h want 0000003f", d); end
    checks++; if (p_oeb !== 38'h3F_0000_001F || p_out !== 38'h00_A5A5_A5A0) begin errors++; $display("FAIL f_hi_pads: oeb %h out %h want 3f0000001f 00a5a5a5a0", p_oeb, p_out); end
    tick();
    wb_write(2'd2, 32'h0, 4'b1111);
    tick();
    wb_write(2'd3, 32'h0, 4'b1111);
    tick(); tick();
    checks++; if (p_out !== T1_PAD || p_oeb !== 38'h1E) begin errors++; $display("FAIL f_cleared: out %h oeb %h want %h 1e", p_out, p_oeb, T1_PAD); end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] d;
    logic a;
    logic stuck;
    stuck = 0;
    wb_write(2'd0, 32'h0000_0102, 4'b0011);
    tick();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (p_oeb !== ALL_IN || p_out !== '0 || t_en !== 4'b0000 || irq !== 1'b0 || ack !== 1'b0 || dat_o !== 32'h0) begin errors++; $display("FAIL mid_rst: oeb %h out %h en %b irq %b ack %b dat %h", p_oeb, p_out, t_en, irq, ack, dat_o); end
    for (int i = 0; i < 7; i++) begin
      tick();
      if (t_en !== 4'b0000 || p_oeb !== ALL_IN) stuck = 1;
    end
    checks++; if (stuck !== 1'b0) begin errors++; $display("FAIL mid_rst_off: left OFF %b want 0", stuck); end
    wb_read(2'd1, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_status: got %h want 0", d); end
    tick();
    wb_read(2'd0, d, a);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_ctrl: got %h want 0", d); end
    tick();
    start_read(2'd1);
    rst = 1;
    tick();
    checks++; if (ack !== 1'b0 || dat_o !== 32'h0) begin errors++; $display("FAIL rst_drop_ack: ack %b dat %h want 0 0", ack, dat_o); end
    bus_idle();
    rst = 0;
    tick();
  endtask

  task automatic test_gpio_in();
    p_in = ALL_IN;
    #1;
`ifdef GPIO_SYNC_EN
    checks++; if (t_in !== '0) begin errors++; $display("FAIL in_c0: got %h want 0", t_in); end
    tick();
    checks++; if (t_in !== '0) begin errors++; $display("FAIL in_c1: got %h want 0", t_in); end
    tick();
`endif
    checks++; if (t_in !== 38'h3F_FFFF_FFE1) begin errors++; $display("FAIL in_val: got %h want 3fffffffe1", t_in); end
    p_in = 38'h00_0000_0014;
    #1;
`ifdef GPIO_SYNC_EN
    tick(); tick();
`endif
    checks++; if (t_in !== '0) begin errors++; $display("FAIL in_rsvd: got %h want 0", t_in); end
  endtask

  initial begin
    test_reset();
    test_held_stb();
    test_drain_owner2();
    test_switch_owner1();
    test_illegal_owner();
    test_force();
    test_reset_mid_drain();
    test_gpio_in();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/team_gpio_mux_wrapper.md
# team_gpio_mux_wrapper

- Parametrised GPIO arbitration wrapper that lets `NUM_TEAMS` team cores share the breakout-board GPIO bank. Exactly one team is the owner at a time.
- Owner selection and enable are programmed by the management core over a Wishbone slave port.
- Every ownership change goes through a break-before-make drain: all pins are forced to input for a programmable number of cycles before the new owner drives.
- Reserved pins (the board-debug pins) stay tri-stated at all times. The block sits between the user-project wrapper's GPIO/Wishbone ports and the team cores.

## Interface
Parameters:
- `NUM_TEAMS`, 4: number of team channels (2..16); `SEL_W = $clog2(NUM_TEAMS)` is a localparam.
- `GPIO_W`, 38: GPIO bank width.
- `RSVD_MASK`, `38'h1E`: pins permanently held as input (pins 4:1).
- `SWITCH_CYCLES`, 4: drain length in cycles (≥1).

Ports:
- `wb_clk_i` in 1: sole clock.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: Wishbone control.
- `wbs_sel_i` in 4: byte enables.
- `wbs_adr_i` in 32: address; only bits [3:2] are decoded.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: single-cycle acknowledge.
- `wbs_dat_o` out 32: read data, registered.
- `team_gpio_out` in `NUM_TEAMS*GPIO_W`: per-team output values; team k occupies slice k.
- `team_gpio_oeb` in `NUM_TEAMS*GPIO_W`: per-team active-low output enables.
- `team_gpio_in` out `GPIO_W`: synchronised pad inputs, broadcast to all teams.
- `team_en` out `NUM_TEAMS`: one-hot, current owner while RUN; 0 otherwise.
- `gpio_in` in `GPIO_W`: pad inputs.
- `gpio_out` out `GPIO_W`: pad outputs.
- `gpio_oeb` out `GPIO_W`: pad active-low output enables.
- `irq` out 1: level, equals STATUS.err.

## Operation
- Register map (word offsets):
  - 0 CTRL, R/W: [SEL_W-1:0] owner, [8] enable.
  - 1 STATUS: [SEL_W-1:0] active owner, [8] running, [9] busy, [10] err (write 1 to clear).
  - 2 FORCE_LO, R/W: force-input mask for pins 31:0.
  - 3 FORCE_HI, R/W: force-input mask for pins [GPIO_W-1:32] in bits [GPIO_W-33:0].
- Byte-enable writes: each byte lane is written only when its `wbs_sel_i` bit is set.
- Wishbone handshake:
  - A request is `cyc & stb & !ack`; it is acked on the next cycle with `wbs_ack_o` high for exactly one cycle.
  - A held `stb` produces a new ack every other cycle.
  - Read data is valid while `ack` is high; `wbs_dat_o` is 0 when `ack` is low.
- Illegal owner: a CTRL write with owner ≥ `NUM_TEAMS` and enable=1 is rejected entirely (CTRL unchanged), sets err, and is still acked.
- State machine states are OFF, DRAIN and RUN. Reset puts it in OFF.
- A CTRL write that changes owner or enable enters DRAIN from any state and loads the counter with `SWITCH_CYCLES-1`.
- A CTRL write that changes neither owner nor enable has no effect on the state machine.
- In DRAIN:
  - The counter decrements every cycle.
  - A qualifying CTRL write during DRAIN reloads the counter and updates the pending owner.
  - At count 0 the state goes to RUN if enable=1, otherwise OFF.
- Pad drive by state:
  - OFF and DRAIN: `gpio_oeb` all 1, `gpio_out` all 0, `team_en` = 0.
  - RUN: `gpio_out`/`gpio_oeb` come from the owner slice, except pins in `RSVD_MASK` or the force mask, which get oeb=1, out=0.
- Reserved pins: `gpio_oeb=1`, `gpio_out=0` in every state. `team_gpio_in` reads 0 on reserved pins.
- Force-mask edits apply in RUN without a drain.
- Reset values: `wbs_ack_o` 0, `wbs_dat_o` 0, `gpio_out` 0, `gpio_oeb` all 1, `team_en` 0, `irq` 0, all registers 0, `team_gpio_in` 0.

## Timing
- A write sampled in cycle T updates registers and raises `ack` in T+1.
- For a drain started by a write sampled in cycle T:
  - State is DRAIN during T+1 .. T+SWITCH_CYCLES.
  - Pads are forced to input from T+2.
  - State is RUN at T+SWITCH_CYCLES+1.
  - The new owner drives the pads at T+SWITCH_CYCLES+2.
- `gpio_out`/`gpio_oeb` are registered: 1-cycle latency from `team_gpio_*` in RUN.
- `team_gpio_in` latency from `gpio_in` is 2 cycles (see Configuration).
- `wb_rst_i` asserted in any state, including mid-DRAIN or mid-transaction:
  - The next cycle shows reset values.
  - Any pending ack is dropped.
- Simultaneous err-clear write and new illegal CTRL write cannot occur (single port). An err-clear write in the same cycle that err would set keeps err=1.

## Configuration
- `GPIO_SYNC_EN` defined: `gpio_in` passes through a 2-flop synchroniser before `team_gpio_in` (2-cycle latency).
- `GPIO_SYNC_EN` undefined: `team_gpio_in = gpio_in & ~RSVD_MASK`, combinational, 0-cycle latency.

## Test plan
- Reset, then read STATUS:
  - `gpio_oeb=38'h3F_FFFF_FFFF`, `gpio_out=0`, `team_en=0`.
  - STATUS reads 0; ack is high exactly 1 cycle.
- Write CTRL=0x102 (owner 2, enable), team 2 drives `out=all 1s`, `oeb=0`:
  - busy=1 for 4 cycles.
  - Then `team_en=4'b0100`.
  - `gpio_out=38'h3F_FFFF_FFE1`, `gpio_oeb=38'h1E`.
- While running owner 2, write CTRL=0x101:
  - Pads go all-input for exactly 4 cycles, then team 1 drives.
  - `team_en` is never two-hot.
- Write CTRL=0x105 with `NUM_TEAMS=4`:
  - CTRL unchanged, err=1, `irq=1`.
  - Writing STATUS bit 10 as 1 clears both.
- In RUN, write FORCE_LO=0x1 with `sel=4'b0001`:
  - Pin 0 `oeb=1`, `out=0` from the next cycle.
  - No drain (busy stays 0).
- Assert `wb_rst_i` at the 2nd DRAIN cycle:
  - Next cycle all outputs are at reset values; state is OFF.
  - `gpio_in` toggles reach `team_gpio_in` after 2 cycles with `GPIO_SYNC_EN`.
